// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared op encodings and FSM state type for the sequential shifter
package alu_pkg;

  localparam logic [2:0] SHOP_SHL  = 3'd0;
  localparam logic [2:0] SHOP_SHR  = 3'd1;
  localparam logic [2:0] SHOP_ASR  = 3'd2;
  localparam logic [2:0] SHOP_ROL  = 3'd3;
  localparam logic [2:0] SHOP_ROR  = 3'd4;
  localparam logic [2:0] SHOP_RCL  = 3'd5;
  localparam logic [2:0] SHOP_RCR  = 3'd6;
  localparam logic [2:0] SHOP_RSVD = 3'd7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/alu_shift_step.sv
// rtl/alu_shift_step.sv - one single-bit shift/rotate step on data plus carry
module alu_shift_step
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] data,
  input  logic             carry,
  input  logic [2:0]       op,
  output logic [WIDTH-1:0] next_data,
  output logic             next_carry
);

  always_comb begin
    next_data  = data;
    next_carry = carry;
    case (op)
      SHOP_SHL: begin
        next_data  = {data[WIDTH-2:0], 1'b0};
        next_carry = data[WIDTH-1];
      end
      SHOP_SHR: begin
        next_data  = {1'b0, data[WIDTH-1:1]};
        next_carry = data[0];
      end
      SHOP_ASR: begin
        next_data  = {data[WIDTH-1], data[WIDTH-1:1]};
        next_carry = data[0];
      end
      SHOP_ROL: begin
        next_data  = {data[WIDTH-2:0], data[WIDTH-1]};
        next_carry = data[WIDTH-1];
      end
      SHOP_ROR: begin
        next_data  = {data[0], data[WIDTH-1:1]};
        next_carry = data[0];
      end
      // Carry acts as the extra bit of a WIDTH+1 rotate.
      SHOP_RCL: begin
        next_data  = {data[WIDTH-2:0], carry};
        next_carry = data[WIDTH-1];
      end
      SHOP_RCR: begin
        next_data  = {carry, data[WIDTH-1:1]};
        next_carry = data[0];
      end
      default: begin
        next_data  = data;
        next_carry = carry;
      end
    endcase
  end

endmodule

// File: rtl/alu_shift_seq.sv
// rtl/alu_shift_seq.sv - multi-cycle shifter, one bit per clock, valid/ready on both sides
module alu_shift_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int AMT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [AMT_W-1:0] amount,
  input  logic             CarryIn,
  input  logic [WIDTH-1:0] LHSIn,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] LHSOut,
  output logic             CarryOut,
  output logic             ZeroOut
);

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] data_q;
  logic             carry_q;
  logic             zero_q;
  logic [2:0]       op_q;
  logic [AMT_W-1:0] count_q;
  logic [WIDTH-1:0] step_data;
  logic             step_carry;
  logic             start_shift;

  alu_shift_step #(.WIDTH(WIDTH)) u_step (
    .data       (data_q),
    .carry      (carry_q),
    .op         (op_q),
    .next_data  (step_data),
    .next_carry (step_carry)
  );

  // The reserved op behaves as a zero-length shift.
  assign start_shift = (op != SHOP_RSVD) && (amount != '0);

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (in_valid) begin
          state_next = start_shift ? SHIFT : DONE;
        end
      end
      SHIFT: begin
        if (count_q == AMT_W'(1)) begin
          state_next = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      data_q  <= '0;
      carry_q <= 1'b0;
      zero_q  <= 1'b1;
      op_q    <= SHOP_SHL;
      count_q <= '0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (in_valid) begin
            data_q  <= LHSIn;
            carry_q <= CarryIn;
            zero_q  <= (LHSIn == '0);
            op_q    <= op;
            count_q <= start_shift ? amount : '0;
          end
        end
        SHIFT: begin
          data_q  <= step_data;
          carry_q <= step_carry;
          zero_q  <= (step_data == '0);
          count_q <= count_q - AMT_W'(1);
        end
        default: begin
        end
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign LHSOut    = data_q;
  assign CarryOut  = carry_q;
  assign ZeroOut   = zero_q;

endmodule

// File: tb/tb_alu_shift_seq.sv
// tb/tb_alu_shift_seq.sv - directed self-checking bench for alu_shift_seq
module tb_alu_shift_seq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [2:0] op = 3'd0;
  logic [3:0] amount = 4'd0;
  logic       CarryIn = 1'b0;
  logic [7:0] LHSIn = 8'h00;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] LHSOut;
  logic       CarryOut;
  logic       ZeroOut;

  int n_checks = 0;
  int n_fail = 0;

  alu_shift_seq #(.WIDTH(8), .AMT_W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .amount    (amount),
    .CarryIn   (CarryIn),
    .LHSIn     (LHSIn),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .LHSOut    (LHSOut),
    .CarryOut  (CarryOut),
    .ZeroOut   (ZeroOut)
  );

  always #5 clk = ~clk;

  // Latency counts the accepting edge as cycle 1; a timeout returns 64.
  task automatic do_request(input logic [2:0] o, input logic [7:0] lhs, input logic cin,
                            input logic [3:0] amt, output int lat);
    @(negedge clk);
    in_valid = 1'b1;
    op       = o;
    LHSIn    = lhs;
    CarryIn  = cin;
    amount   = amt;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 64) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic release_result();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    n_checks++; if (LHSOut !== 8'h00) begin n_fail++; $display("FAIL reset_lhs: got %h expected 00", LHSOut); end
    n_checks++; if (CarryOut !== 1'b0) begin n_fail++; $display("FAIL reset_carry: got %b expected 0", CarryOut); end
    n_checks++; if (ZeroOut !== 1'b1) begin n_fail++; $display("FAIL reset_zero: got %b expected 1", ZeroOut); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_shl();
    int lat;
    do_request(3'b000, 8'h81, 1'b0, 4'd1, lat);
    n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL shl_latency: got %0d expected 2", lat); end
    n_checks++; if (LHSOut !== 8'h02) begin n_fail++; $display("FAIL shl_data: got %h expected 02", LHSOut); end
    n_checks++; if (CarryOut !== 1'b1) begin n_fail++; $display("FAIL shl_carry: got %b expected 1", CarryOut); end
    n_checks++; if (ZeroOut !== 1'b0) begin n_fail++; $display("FAIL shl_zero: got %b expected 0", ZeroOut); end
    release_result();
  endtask

  task automatic test_asr_shr();
    int lat;
    do_request(3'b010, 8'h80, 1'b1, 4'd3, lat);
    n_checks++; if (lat !== 4) begin n_fail++; $display("FAIL asr_latency: got %0d expected 4", lat); end
    n_checks++; if (LHSOut !== 8'hF0) begin n_fail++; $display("FAIL asr_data: got %h expected f0", LHSOut); end
    n_checks++; if (CarryOut !== 1'b0) begin n_fail++; $display("FAIL asr_carry: got %b expected 0", CarryOut); end
    release_result();
    do_request(3'b001, 8'hFF, 1'b1, 4'd15, lat);
    n_checks++; if (lat !== 16) begin n_fail++; $display("FAIL shr15_latency: got %0d expected 16", lat); end
    n_checks++; if (LHSOut !== 8'h00) begin n_fail++; $display("FAIL shr15_data: got %h expected 00", LHSOut); end
    n_checks++; if (CarryOut !== 1'b0) begin n_fail++; $display("FAIL shr15_carry: got %b expected 0", CarryOut); end
    n_checks++; if (ZeroOut !== 1'b1) begin n_fail++; $display("FAIL shr15_zero: got %b expected 1", ZeroOut); end
    release_result();
  endtask

  task automatic test_rotate();
    int lat;
    do_request(3'b100, 8'h01, 1'b0, 4'd1, lat);
    n_checks++; if (LHSOut !== 8'h80) begin n_fail++; $display("FAIL ror_data: got %h expected 80", LHSOut); end
    n_checks++; if (CarryOut !== 1'b1) begin n_fail++; $display("FAIL ror_carry: got %b expected 1", CarryOut); end
    release_result();
    do_request(3'b101, 8'h80, 1'b0, 4'd9, lat);
    n_checks++; if (lat !== 10) begin n_fail++; $display("FAIL rcl9_latency: got %0d expected 10", lat); end
    n_checks++; if (LHSOut !== 8'h80) begin n_fail++; $display("FAIL rcl9_data: got %h expected 80", LHSOut); end
    n_checks++; if (CarryOut !== 1'b0) begin n_fail++; $display("FAIL rcl9_carry: got %b expected 0", CarryOut); end
    release_result();
    // 0x81 rotated left twice: 0x03 then 0x06, last bit out is 0.
    do_request(3'b011, 8'h81, 1'b1, 4'd2, lat);
    n_checks++; if (LHSOut !== 8'h06) begin n_fail++; $display("FAIL rol2_data: got %h expected 06", LHSOut); end
    n_checks++; if (CarryOut !== 1'b0) begin n_fail++; $display("FAIL rol2_carry: got %b expected 0", CarryOut); end
    release_result();
  endtask

  task automatic test_zero_amount();
    int lat;
    do_request(3'b001, 8'h55, 1'b1, 4'd0, lat);
    n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL amt0_latency: got %0d expected 1", lat); end
    n_checks++; if (LHSOut !== 8'h55) begin n_fail++; $display("FAIL amt0_data: got %h expected 55", LHSOut); end
    n_checks++; if (CarryOut !== 1'b1) begin n_fail++; $display("FAIL amt0_carry: got %b expected 1", CarryOut); end
    release_result();
    do_request(3'b111, 8'h55, 1'b1, 4'd5, lat);
    n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL rsvd_latency: got %0d expected 1", lat); end
    n_checks++; if (LHSOut !== 8'h55) begin n_fail++; $display("FAIL rsvd_data: got %h expected 55", LHSOut); end
    n_checks++; if (CarryOut !== 1'b1) begin n_fail++; $display("FAIL rsvd_carry: got %b expected 1", CarryOut); end
    release_result();
  endtask

  task automatic test_backpressure();
    int lat;
    do_request(3'b011, 8'h81, 1'b1, 4'd2, lat);
    @(negedge clk);
    in_valid = 1'b1;
    op       = 3'b000;
    LHSIn    = 8'hAA;
    CarryIn  = 1'b0;
    amount   = 4'd0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_out_valid[%0d]: got %b expected 1", i, out_valid); end
      n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready[%0d]: got %b expected 0", i, in_ready); end
      n_checks++; if (LHSOut !== 8'h06) begin n_fail++; $display("FAIL bp_data[%0d]: got %h expected 06", i, LHSOut); end
      n_checks++; if (CarryOut !== 1'b0) begin n_fail++; $display("FAIL bp_carry[%0d]: got %b expected 0", i, CarryOut); end
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_idle_in_ready: got %b expected 1", in_ready); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_idle_out_valid: got %b expected 0", out_valid); end
    @(negedge clk);
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_next_valid: got %b expected 1", out_valid); end
    n_checks++; if (LHSOut !== 8'hAA) begin n_fail++; $display("FAIL bp_next_data: got %h expected aa", LHSOut); end
    n_checks++; if (CarryOut !== 1'b0) begin n_fail++; $display("FAIL bp_next_carry: got %b expected 0", CarryOut); end
    release_result();
  endtask

  task automatic test_reset_mid_shift();
    int lat;
    @(negedge clk);
    in_valid = 1'b1;
    op       = 3'b000;
    LHSIn    = 8'h01;
    CarryIn  = 1'b0;
    amount   = 4'd10;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_out_valid: got %b expected 0", out_valid); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_mid_in_ready: got %b expected 1", in_ready); end
    n_checks++; if (LHSOut !== 8'h00) begin n_fail++; $display("FAIL rst_mid_data: got %h expected 00", LHSOut); end
    @(negedge clk);
    rst_n = 1'b1;
    // RCR 0x01 with carry 0 twice: 0x00/c1 then 0x80/c0.
    do_request(3'b110, 8'h01, 1'b0, 4'd2, lat);
    n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL post_rst_latency: got %0d expected 3", lat); end
    n_checks++; if (LHSOut !== 8'h80) begin n_fail++; $display("FAIL post_rst_data: got %h expected 80", LHSOut); end
    n_checks++; if (CarryOut !== 1'b0) begin n_fail++; $display("FAIL post_rst_carry: got %b expected 0", CarryOut); end
    release_result();
  endtask

  initial begin
    test_reset();
    test_shl();
    test_asr_shr();
    test_rotate();
    test_zero_amount();
    test_backpressure();
    test_reset_mid_shift();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
